// File: rtl/digdar_pkg.sv
// Shared definitions for the capture-buffer readout path.
// Region offsets, channel codes, sequencer states and channel-walk helpers.
// Pure declarations: no timing and no flow control of its own.
package digdar_pkg;

   localparam logic [19:0] ADC_A_OFS  = 20'h10000;
   localparam logic [19:0] ADC_B_OFS  = 20'h20000;
   localparam logic [19:0] XADC_A_OFS = 20'h30000;
   localparam logic [19:0] XADC_B_OFS = 20'h40000;

   localparam logic [1:0] CH_ADC_A  = 2'd0;
   localparam logic [1:0] CH_ADC_B  = 2'd1;
   localparam logic [1:0] CH_XADC_A = 2'd2;
   localparam logic [1:0] CH_XADC_B = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_PUSH     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Scope region offset for a channel code.
   function automatic logic [19:0] region_ofs(input logic [1:0] chan);
      logic [19:0] ofs;
      case (chan)
         CH_ADC_A:  ofs = ADC_A_OFS;
         CH_ADC_B:  ofs = ADC_B_OFS;
         CH_XADC_A: ofs = XADC_A_OFS;
         default:   ofs = XADC_B_OFS;
      endcase
      return ofs;
   endfunction

   // Lowest enabled channel above cur; MSB flags whether one exists.
   function automatic logic [2:0] next_chan(input logic [3:0] mask, input logic [1:0] cur);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (i > int'(cur) && mask[i]) res = {1'b1, 2'(i)};
      end
      return res;
   endfunction

   // Lowest enabled channel in the mask (0 when the mask is empty).
   function automatic logic [1:0] first_chan(input logic [3:0] mask);
      logic [1:0] res;
      res = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) res = 2'(i);
      end
      return res;
   endfunction

endpackage

// File: rtl/sys_bus_read_port.sv
// Single-beat system-bus read: strobe, hold address, wait for ack/err/timeout.
// Strobe is combinational on issue; response status is combinational on the ack cycle.
// No backpressure: the sequencer keeps at most one read outstanding.
module sys_bus_read_port
   import digdar_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        sys_clk_i,
   input  logic        sys_rstn_i,
   input  logic        issue,
   input  logic        waiting,
   input  logic [31:0] addr,
   output logic [31:0] sys_addr_o,
   output logic        sys_ren_o,
   input  logic [31:0] sys_rdata_i,
   input  logic        sys_err_i,
   input  logic        sys_ack_i,
   output logic        rsp_ok,
   output logic        rsp_err,
   output logic [31:0] rsp_data
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

   logic [31:0]   addr_q;
   logic [TW-1:0] wait_cnt;
   logic          timed_out;

   // Capture the address on the strobe cycle and count cycles spent waiting.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         addr_q   <= 32'h0;
         wait_cnt <= '0;
      end else if (issue) begin
         addr_q   <= addr;
         wait_cnt <= TW'(1);
      end else if (waiting && !timed_out) begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end

   assign timed_out  = (wait_cnt == TMO);
   assign sys_ren_o  = issue;
   assign sys_addr_o = issue ? addr : addr_q;
   assign rsp_ok     = waiting && sys_ack_i && !sys_err_i;
   // An ack on the last counted cycle still wins over the timeout.
   assign rsp_err    = waiting && ((sys_ack_i && sys_err_i) || (!sys_ack_i && timed_out));
   assign rsp_data   = sys_rdata_i;

endmodule

// File: rtl/digdar_capture_reader.sv
// Drains scope capture buffers over the sys bus into a tagged valid/ready stream.
// Start to first strobe 1 cycle; ack to m_valid_o 1 cycle; next strobe the cycle after handshake.
// m_valid_o holds data/chan/last until m_ready_i; no new read is issued while stalled.
module digdar_capture_reader
   import digdar_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4010_0000,
   parameter int          TIMEOUT   = 1024,
   parameter int          RSZ       = 14
) (
   input  logic         sys_clk_i,
   input  logic         sys_rstn_i,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic [RSZ:0] n_samples_i,
   input  logic [3:0]   chan_mask_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [31:0]  sys_addr_o,
   output logic [31:0]  sys_wdata_o,
   output logic [3:0]   sys_sel_o,
   output logic         sys_wen_o,
   output logic         sys_ren_o,
   input  logic [31:0]  sys_rdata_i,
   input  logic         sys_err_i,
   input  logic         sys_ack_i,
   output logic [31:0]  m_data_o,
   output logic [1:0]   m_chan_o,
   output logic         m_last_o,
   output logic         m_valid_o,
   input  logic         m_ready_i
);

   state_t       state, state_nxt;
   logic [RSZ:0] cfg_n;
   logic [3:0]   cfg_mask;
   logic [1:0]   chan;
   logic [RSZ:0] idx;
   logic [RSZ:0] words;
   logic         last_in_chan;
   logic [2:0]   nxt;
   logic         frame_last;
   logic         start_ok;
   logic         cfg_empty;
   logic         empty_done_q;
   logic [31:0]  rd_addr;
   logic         rsp_ok, rsp_err;
   logic [31:0]  rsp_data;

   assign sys_wdata_o = 32'h0;
   assign sys_sel_o   = 4'hF;
   assign sys_wen_o   = 1'b0;

   // ADC A packs two 16-bit samples per word, so it needs half as many reads.
   assign words        = (chan == CH_ADC_A) ? ((cfg_n + (RSZ+1)'(1)) >> 1) : cfg_n;
   assign last_in_chan = (idx == words - (RSZ+1)'(1));
   assign nxt          = next_chan(cfg_mask, chan);
   assign frame_last   = last_in_chan && !nxt[2];
   assign start_ok     = (state == ST_IDLE) && start_i && !abort_i;
   assign cfg_empty    = (n_samples_i == '0) || (chan_mask_i == 4'h0);
   assign rd_addr      = BASE_ADDR + {12'h000, region_ofs(chan)} + {{(32-RSZ-3){1'b0}}, idx, 2'b00};

   sys_bus_read_port #(.TIMEOUT(TIMEOUT)) u_port (
      .sys_clk_i   (sys_clk_i),
      .sys_rstn_i  (sys_rstn_i),
      .issue       (state == ST_ISSUE),
      .waiting     (state == ST_WAIT_ACK),
      .addr        (rd_addr),
      .sys_addr_o  (sys_addr_o),
      .sys_ren_o   (sys_ren_o),
      .sys_rdata_i (sys_rdata_i),
      .sys_err_i   (sys_err_i),
      .sys_ack_i   (sys_ack_i),
      .rsp_ok      (rsp_ok),
      .rsp_err     (rsp_err),
      .rsp_data    (rsp_data)
   );

   // Sequencer state register.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) state <= ST_IDLE;
      else             state <= state_nxt;
   end

   // Next-state and status outputs; abort overrides every non-idle transition.
   always_comb begin
      state_nxt = state;
      busy_o    = (state != ST_IDLE);
      m_valid_o = (state == ST_PUSH);
      done_o    = (state == ST_DONE) || empty_done_q;
      case (state)
         ST_IDLE:     if (start_ok && !cfg_empty) state_nxt = ST_ISSUE;
         ST_ISSUE:    state_nxt = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (rsp_ok)       state_nxt = ST_PUSH;
            else if (rsp_err) state_nxt = ST_IDLE;
         end
         ST_PUSH:     if (m_ready_i) state_nxt = m_last_o ? ST_DONE : ST_ISSUE;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
      if (abort_i && state != ST_IDLE) state_nxt = ST_IDLE;
   end

   // Config latch, channel/index walk, stream register and sticky error.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         cfg_n        <= '0;
         cfg_mask     <= 4'h0;
         chan         <= 2'd0;
         idx          <= '0;
         err_o        <= 1'b0;
         empty_done_q <= 1'b0;
         m_data_o     <= 32'h0;
         m_chan_o     <= 2'd0;
         m_last_o     <= 1'b0;
      end else begin
         empty_done_q <= start_ok && cfg_empty;
         if (start_ok) begin
            cfg_n    <= n_samples_i;
            cfg_mask <= chan_mask_i;
            chan     <= first_chan(chan_mask_i);
            idx      <= '0;
            err_o    <= 1'b0;
         end
         if (state == ST_WAIT_ACK && !abort_i) begin
            if (rsp_ok) begin
               m_data_o <= rsp_data;
               m_chan_o <= chan;
               m_last_o <= frame_last;
            end else if (rsp_err) begin
               err_o <= 1'b1;
            end
         end
         if (state == ST_PUSH && m_ready_i && !abort_i) begin
            if (last_in_chan) begin
               chan <= nxt[1:0];
               idx  <= '0;
            end else begin
               idx <= idx + (RSZ+1)'(1);
            end
         end
      end
   end

endmodule
